soc_addr_router: RTL
====================

SOC_ADDR_ROUTER -- requirements
Module: soc_addr_router

Interface
REQ-001 Parameter IdWidth, default 4: width of the request/response transaction ID.
REQ-002 Parameter DramLength, default 64'h4000_0000: size of the DRAM window; a board variant sets 64'h2000_0000.
REQ-003 Port clk_i, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 Ports req_valid_i (in, 1), req_ready_o (out, 1), req_addr_i (in, 64), req_id_i (in, IdWidth), req_we_i (in, 1): upstream request channel.
REQ-006 Ports slv_valid_o (out, 1), slv_ready_i (in, 1), slv_sel_o (out, 4), slv_addr_o (out, 64), slv_id_o (out, IdWidth), slv_we_o (out, 1): routed request to the selected peripheral index.
REQ-007 Ports rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_id_o (out, IdWidth), rsp_err_o (out, 1): locally generated decode-error response channel.
REQ-008 Port err_cnt_o, output, 16: saturating count of decode errors.

Function
REQ-009 Decode rule: a region hits iff base <= addr < base+length, using unsigned 64-bit compares with no overflow.
REQ-010 Region map as index, base, length:
- 0 DRAM, 8000_0000, DramLength
- 1 Trigger, 4001_0000, 1000
- 2 GPIO, 4000_0000, 1000
- 3 Ethernet, 3000_0000, 10000
- 4 SPI, 2000_0000, 80_0000
- 5 Timer, 1800_0000, 1000
- 6 UART, 1000_0000, 1000
- 7 PLIC, 0C00_0000, 3FF_FFFF
- 8 CLINT, 0200_0000, C_0000
- 9 ROM, 1_0000, 1_0000
- 10 Debug, 0, 1000
REQ-011 Regions are disjoint; exactly zero or one region hits for any address.
REQ-012 The FSM has three states:
- IDLE: req_ready_o=1; no other valid outputs asserted.
- FWD: slv_valid_o=1.
- ERR: rsp_valid_o=1, rsp_err_o=1.
REQ-013 In IDLE, a request is accepted when req_valid_i=1; addr, id, we and the decoded index are registered.
- On a hit, the next state is FWD.
- On a miss, the next state is ERR.
REQ-014 Accept-to-output latency is exactly 1 cycle: slv_valid_o or rsp_valid_o rises in the cycle after acceptance.
REQ-015 In FWD, slv_sel_o/slv_addr_o/slv_id_o/slv_we_o hold the registered values and stay stable while slv_valid_o=1 and slv_ready_i=0.
REQ-016 In FWD, slv_valid_o=1 and slv_ready_i=1 moves the FSM to IDLE.
REQ-017 In ERR, rsp_id_o equals the registered ID.
REQ-018 In ERR, rsp_valid_o=1 and rsp_ready_i=1 moves the FSM to IDLE.
REQ-019 req_ready_o is 0 in FWD and ERR: one outstanding transaction maximum, and no new acceptance in the cycle a handshake completes. Maximum throughput is therefore one transaction per 2 cycles.
REQ-020 slv_valid_o and rsp_valid_o never deassert before their handshake completes and are never both 1.
REQ-021 err_cnt_o increments by 1 on each accepted missed request, and saturates at 16'hFFFF.
REQ-022 slv_ready_i is ignored outside FWD; rsp_ready_i is ignored outside ERR.
REQ-023 When rsp_valid_o=0, rsp_err_o=0 and rsp_id_o=0.
REQ-024 When slv_valid_o=0, slv_sel_o, slv_addr_o, slv_id_o and slv_we_o hold their last value and are don't-care.

Reset
REQ-025 On rst_ni=0, the FSM goes to IDLE immediately (asynchronously).
REQ-026 The reset value of slv_valid_o and rsp_valid_o is 0.
REQ-027 The reset value of rsp_err_o, rsp_id_o, slv_sel_o, slv_addr_o, slv_id_o, slv_we_o and err_cnt_o is 0.
REQ-028 The reset value of req_ready_o is 1 (IDLE).
REQ-029 Reset asserted mid-transaction (FWD or ERR) drops the pending transaction without completing a handshake; the counter clears.
REQ-030 After rst_ni deasserts, the first acceptance occurs on the first rising edge with req_valid_i=1.

Verification
REQ-031 Request addr 0x1000_0004, id 3, we 1, slv_ready_i=1 -> next cycle slv_valid_o=1, slv_sel_o=6, slv_id_o=3; IDLE the cycle after.
REQ-032 Boundary addresses:
- 0x0000_0FFF -> sel 10
- 0x0000_1000 -> error
- 0x0001_FFFF -> sel 9
- 0x0FFF_FFFE -> sel 7
- 0x0FFF_FFFF -> error
- 0xBFFF_FFFF -> sel 0
- 0xC000_0000 -> error
- 0xBFFF_FFFF with DramLength=2000_0000 -> error
REQ-033 Request addr 0x5000_0000, id 9 (IdWidth=4) with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o=1, rsp_err_o=1, rsp_id_o=9 stable for 5 cycles; IDLE after the handshake; err_cnt_o=1.
REQ-034 Backpressure: slv_ready_i=0 for 3 cycles with req_valid_i held 1 -> req_ready_o=0 and slv outputs stable throughout; exactly one slave handshake occurs.
REQ-035 err_cnt_o preloaded near saturation through 65536 consecutive misses -> err_cnt_o stays 16'hFFFF.
REQ-036 rst_ni pulsed low in FWD with slv_ready_i=0 -> slv_valid_o=0 asynchronously, req_ready_o=1, err_cnt_o=0.

Source files
------------

// File: rtl/soc_addr_router.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// soc_addr_router
// Decodes one upstream request at a time against a fixed SoC region map and
// either forwards it to the selected peripheral index or answers it locally
// with a decode-error response.
//
// Ports
//    clk_i, rst_ni                  clock, asynchronous active-low reset
//    req_valid_i/req_ready_o        upstream request handshake
//    req_addr_i/req_id_i/req_we_i   upstream request payload
//    slv_valid_o/slv_ready_i        routed request handshake
//    slv_sel_o                      peripheral index (0..10) of the hit region
//    slv_addr_o/slv_id_o/slv_we_o   routed request payload
//    rsp_valid_o/rsp_ready_i        decode-error response handshake
//    rsp_id_o/rsp_err_o             decode-error response payload
//    err_cnt_o                      saturating count of decode errors
// -----------------------------------------------------------------------------
module soc_addr_router #(
   parameter int          IdWidth    = 4,
   parameter logic [63:0] DramLength = 64'h4000_0000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [63:0]        req_addr_i,
   input  logic [IdWidth-1:0] req_id_i,
   input  logic               req_we_i,
   output logic               slv_valid_o,
   input  logic               slv_ready_i,
   output logic [3:0]         slv_sel_o,
   output logic [63:0]        slv_addr_o,
   output logic [IdWidth-1:0] slv_id_o,
   output logic               slv_we_o,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [IdWidth-1:0] rsp_id_o,
   output logic               rsp_err_o,
   output logic [15:0]        err_cnt_o
);

   localparam int NumRegions = 11;

   function automatic logic [63:0] region_base(input int idx);
      case (idx)
         0:       return 64'h8000_0000;
         1:       return 64'h4001_0000;
         2:       return 64'h4000_0000;
         3:       return 64'h3000_0000;
         4:       return 64'h2000_0000;
         5:       return 64'h1800_0000;
         6:       return 64'h1000_0000;
         7:       return 64'h0C00_0000;
         8:       return 64'h0200_0000;
         9:       return 64'h0001_0000;
         default: return 64'h0000_0000;
      endcase
   endfunction

   function automatic logic [63:0] region_length(input int idx);
      case (idx)
         0:       return DramLength;
         1:       return 64'h0000_1000;
         2:       return 64'h0000_1000;
         3:       return 64'h0001_0000;
         4:       return 64'h0080_0000;
         5:       return 64'h0000_1000;
         6:       return 64'h0000_1000;
         7:       return 64'h03FF_FFFF;
         8:       return 64'h000C_0000;
         9:       return 64'h0001_0000;
         default: return 64'h0000_1000;
      endcase
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t                  state_reg;
   logic                    req_ready_reg;
   logic                    slv_valid_reg;
   logic [3:0]              slv_sel_reg;
   logic [63:0]             slv_addr_reg;
   logic [IdWidth-1:0]      slv_id_reg;
   logic                    slv_we_reg;
   logic                    rsp_valid_reg;
   logic [IdWidth-1:0]      rsp_id_reg;
   logic                    rsp_err_reg;
   logic [15:0]             err_cnt_reg;

   logic [NumRegions-1:0]   region_hit;
   logic [3:0]              hit_sel;
   logic                    hit_any;

   // Compares are done at 65 bits so base+length can never wrap.
   logic [64:0] addr_ext;
   assign addr_ext = {1'b0, req_addr_i};

   generate
      for (genvar gi = 0; gi < NumRegions; gi++) begin : g_region
         localparam logic [64:0] RegionLo = {1'b0, region_base(gi)};
         localparam logic [64:0] RegionHi = RegionLo + {1'b0, region_length(gi)};
         assign region_hit[gi] = (addr_ext >= RegionLo) && (addr_ext < RegionHi);
      end
   endgenerate

   // Regions are disjoint, so at most one bit of region_hit is set.
   always_comb begin
      hit_sel = 4'd0;
      for (int i = 0; i < NumRegions; i++) begin
         if (region_hit[i]) begin
            hit_sel = 4'(i);
         end
      end
   end

   assign hit_any = |region_hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= ST_IDLE;
         req_ready_reg <= 1'b1;
         slv_valid_reg <= 1'b0;
         slv_sel_reg   <= 4'd0;
         slv_addr_reg  <= 64'd0;
         slv_id_reg    <= '0;
         slv_we_reg    <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_err_reg   <= 1'b0;
         err_cnt_reg   <= 16'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid_i) begin
                  req_ready_reg <= 1'b0;
                  if (hit_any) begin
                     // Payload registers only move on a hit so the slave
                     // side keeps its last routed request otherwise.
                     state_reg     <= ST_FWD;
                     slv_valid_reg <= 1'b1;
                     slv_sel_reg   <= hit_sel;
                     slv_addr_reg  <= req_addr_i;
                     slv_id_reg    <= req_id_i;
                     slv_we_reg    <= req_we_i;
                  end else begin
                     state_reg     <= ST_ERR;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                     rsp_id_reg    <= req_id_i;
                     if (err_cnt_reg != 16'hFFFF) begin
                        err_cnt_reg <= err_cnt_reg + 16'd1;
                     end
                  end
               end
            end
            ST_FWD: begin
               if (slv_ready_i) begin
                  state_reg     <= ST_IDLE;
                  slv_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
               end
            end
            ST_ERR: begin
               if (rsp_ready_i) begin
                  // Response fields return to zero whenever rsp_valid_o is low.
                  state_reg     <= ST_IDLE;
                  rsp_valid_reg <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rsp_id_reg    <= '0;
                  req_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               req_ready_reg <= 1'b1;
               slv_valid_reg <= 1'b0;
               rsp_valid_reg <= 1'b0;
               rsp_err_reg   <= 1'b0;
               rsp_id_reg    <= '0;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_reg;
   assign slv_valid_o = slv_valid_reg;
   assign slv_sel_o   = slv_sel_reg;
   assign slv_addr_o  = slv_addr_reg;
   assign slv_id_o    = slv_id_reg;
   assign slv_we_o    = slv_we_reg;
   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_id_o    = rsp_id_reg;
   assign rsp_err_o   = rsp_err_reg;
   assign err_cnt_o   = err_cnt_reg;

endmodule
